// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier issue queue.
package mult_pkg;

   // Operand and product width; must match the attached mult unit
   localparam int unsigned WIDTH = 64;

   // One queued multiply request
   typedef struct packed {
      logic [WIDTH-1:0] mcand;
      logic [WIDTH-1:0] mplier;
   } operand_pair_t;

   // Issue sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } mq_state_t;

endpackage

// File: rtl/mult_fifo.sv
// Synchronous FIFO of operand pairs; occupancy counter drives full/empty.
module mult_fifo
   import mult_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  operand_pair_t din,
   output operand_pair_t head_c,
   output logic [CW-1:0] count
);

   operand_pair_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Full/empty come from count, so pointer equality is never ambiguous
   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head_c  = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while their slot is empty
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mult_issue_queue.sv
// Queues operand pairs and issues them one at a time to the sequential mult unit.
module mult_issue_queue
   import mult_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mcand,
   input  logic [WIDTH-1:0] in_mplier,
   output logic             mult_start,
   output logic [WIDTH-1:0] mult_mcand,
   output logic [WIDTH-1:0] mult_mplier,
   input  logic [WIDTH-1:0] mult_product,
   input  logic             mult_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_product,
   output logic [CW-1:0]    count,
   output logic             busy
);

   mq_state_t     state;
   mq_state_t     state_n;
   operand_pair_t in_pair_c;
   operand_pair_t head_c;
   logic          pop_c;
   logic          capture_c;
   logic          slot_free_c;

   assign in_pair_c   = '{mcand: in_mcand, mplier: in_mplier};
   assign in_ready    = (count < CW'(DEPTH));
   assign slot_free_c = !out_valid || out_ready;

   mult_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .push   (in_valid),
      .pop    (pop_c),
      .din    (in_pair_c),
      .head_c (head_c),
      .count  (count)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next state; issue only when the result slot will be free to take the product
   always_comb begin
      state_n   = state;
      pop_c     = 1'b0;
      capture_c = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && slot_free_c) begin
               state_n = ISSUE;
               pop_c   = 1'b1;
            end
         end
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (mult_done) begin
               state_n   = IDLE;
               capture_c = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered operand/start outputs toward mult, held stable while it works
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mult_start  <= 1'b0;
         mult_mcand  <= '0;
         mult_mplier <= '0;
         busy        <= 1'b0;
      end else begin
         mult_start <= pop_c;
         busy       <= (state_n != IDLE);
         if (pop_c) begin
            mult_mcand  <= head_c.mcand;
            mult_mplier <= head_c.mplier;
         end
      end
   end

   // Result register toward the consumer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_product <= '0;
      end else if (capture_c) begin
         out_valid   <= 1'b1;
         out_product <= mult_product;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Scoreboard bench for mult_issue_queue with a behavioural sequential multiplier.
module tb_mult_issue_queue;
   import mult_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int          LAT   = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mcand;
   logic [WIDTH-1:0] in_mplier;
   logic             mult_start;
   logic [WIDTH-1:0] mult_mcand;
   logic [WIDTH-1:0] mult_mplier;
   logic [WIDTH-1:0] mult_product;
   logic             mult_done;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_product;
   logic [2:0]       count;
   logic             busy;

   int               checks = 0;
   int               errors = 0;
   int               starts = 0;
   int               outs   = 0;
   logic [63:0]      exp_q[$];
   bit               hold_prev = 0;
   logic [63:0]      held_val;
   int               mcnt;

   always #5 clock = ~clock;

   mult_issue_queue #(.DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mcand     (in_mcand),
      .in_mplier    (in_mplier),
      .mult_start   (mult_start),
      .mult_mcand   (mult_mcand),
      .mult_mplier  (mult_mplier),
      .mult_product (mult_product),
      .mult_done    (mult_done),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_product  (out_product),
      .count        (count),
      .busy         (busy)
   );

   // Behavioural mult: done drops on the start edge, rises LAT edges later and stays high
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mult_done    <= 1'b0;
         mult_product <= '0;
         mcnt         <= 0;
      end else if (mult_start) begin
         mult_done <= 1'b0;
         mcnt      <= LAT;
      end else if (mcnt > 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) begin
            mult_done    <= 1'b1;
            mult_product <= mult_mcand * mult_mplier;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: inspects the handshake that the next rising edge will complete
   always @(negedge clock) begin
      if (reset) begin
         if (mult_start) starts++;
         chk("start_with_valid", 64'(mult_start && out_valid), 64'd0);
         if (hold_prev) chk("hold_stable", out_product, held_val);
         if (out_valid && out_ready) begin
            outs++;
            if (exp_q.size() == 0) chk("unexpected_out", out_product, 64'hX);
            else                   chk("product", out_product, exp_q.pop_front());
         end
         hold_prev = out_valid && !out_ready;
         held_val  = out_product;
      end else begin
         hold_prev = 0;
      end
   end

   // Offer one pair until accepted; record its hand-computed product at acceptance
   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
      bit ok = 0;
      in_valid  = 1'b1;
      in_mcand  = a;
      in_mplier = b;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clock);
         if (in_ready) begin
            ok = 1;
            exp_q.push_back(exp);
         end
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      chk("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_drain(input string name);
      bit done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge clock); #1;
         if (exp_q.size() == 0 && !out_valid && !busy && count == 3'd0) done = 1;
      end
      chk(name, 64'(done), 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int s0;
      int o0;
      logic [63:0] a;
      logic [63:0] b;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_mcand  = '0;
      in_mplier = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_start", 64'(mult_start), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mcand", mult_mcand, 64'd0);
      chk("rst_product", out_product, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b1;
      @(posedge clock); #1;

      // Single op and issue latency
      out_ready = 1'b1;
      s0 = starts;
      send(64'd2, 64'd3, 64'h6);
      @(posedge clock); #1;
      chk("latency_start", 64'(mult_start), 64'd1);
      chk("latency_busy", 64'(busy), 64'd1);
      wait_drain("single_drain");
      chk("single_starts", 64'(starts - s0), 64'd1);
      chk("single_busy_idle", 64'(busy), 64'd0);

      // Back-to-back pushes, signed operands wrap
      s0 = starts;
      o0 = outs;
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);
      send(64'hFFFF_FFFF_FFFF_FFEC, 64'd5, 64'hFFFF_FFFF_FFFF_FF9C);
      send(64'd2, 64'd3, 64'h6);
      wait_drain("b2b_drain");
      chk("b2b_starts", 64'(starts - s0), 64'd3);
      chk("b2b_outs", 64'(outs - o0), 64'd3);

      // Backpressure: one issued, four queued, sixth refused
      out_ready = 1'b0;
      s0 = starts;
      o0 = outs;
      send(64'd1, 64'd1, 64'h1);
      send(64'd2, 64'd2, 64'h4);
      send(64'd3, 64'd5, 64'hF);
      send(64'd10, 64'd10, 64'h64);
      send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_count", 64'(count), 64'd4);
      in_valid  = 1'b1;
      in_mcand  = 64'd7;
      in_mplier = 64'd7;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (i % 4 == 0) chk("bp_refuse", 64'(in_ready), 64'd0);
         @(posedge clock); #1;
      end
      chk("bp_one_start", 64'(starts - s0), 64'd1);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_count_hold", 64'(count), 64'd4);

      // Full FIFO: a pop does not open the door for a same-cycle push
      out_ready = 1'b1;
      @(negedge clock);
      chk("full_refuse", 64'(in_ready), 64'd0);
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk("full_pop_count", 64'(count), 64'd3);
      @(negedge clock);
      chk("full_then_ready", 64'(in_ready), 64'd1);
      if (in_ready) exp_q.push_back(64'h31);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("full_push_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      wait_drain("bp_drain");
      chk("bp_outs", 64'(outs - o0), 64'd6);
      chk("bp_starts", 64'(starts - s0), 64'd6);

      // Reset while waiting on mult
      send(64'h1_2345_6789, 64'h10, 64'h12_3456_7890);
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("pre_rst_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_start", 64'(mult_start), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b1;
      @(posedge clock); #1;
      o0 = outs;
      send(64'd7, 64'd6, 64'h2A);
      wait_drain("post_rst_drain");
      chk("post_rst_outs", 64'(outs - o0), 64'd1);

      // Random soak
      o0 = outs;
      for (int i = 0; i < 10000; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         in_valid  = 1'($urandom_range(0, 1));
         in_mcand  = a;
         in_mplier = b;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         if (in_valid && in_ready) exp_q.push_back(a * b);
         @(posedge clock); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("soak_drain");
      chk("soak_progress", 64'(outs - o0 > 100), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
